mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC's single-port data RAM.
- Master 0 is the core load/store port. Master 1 is a program loader/debug port that fills or inspects memory.
- Grants at most one access per cycle: round-robin with a bounded burst allowance.
- Routes each 1-cycle-latency read response back to the master that issued the read.

Parameters:
- ADDR_W, 32, address width of masters and slave.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- BURST_MAX, 4, max consecutive grants to one master while the other is requesting (>=1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- m0_req  input  1  master 0 access request
- m0_we  input  1  master 0 write (1) / read (0)
- m0_addr  input  ADDR_W  master 0 address
- m0_wdata  input  DATA_W  master 0 write data
- m0_be  input  DATA_W/8  master 0 byte enables
- m0_gnt  output  1  master 0 request accepted this cycle
- m0_rvalid  output  1  master 0 read data valid
- m0_rdata  output  DATA_W  master 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
- s_req  output  1  slave access strobe
- s_we  output  1  slave write
- s_addr  output  ADDR_W  slave address
- s_wdata  output  DATA_W  slave write data
- s_be  output  DATA_W/8  slave byte enables
- s_rdata  input  DATA_W  slave read data, valid 1 cycle after an accepted read

Behaviour:
- Clock/reset: single clock clk; rst is asynchronous, active-low. While rst=0:
  - state=IDLE, last=1, cnt=0.
  - m0_rvalid=m1_rvalid=0; pending read tag cleared.
- Outputs during reset:
  - Grants are combinational from state and req, so they are forced to 0 while rst=0.
  - s_req therefore also reads 0 during reset.
- Handshake:
  - A master holds req and all request fields stable until it sees gnt high on a rising edge.
  - gnt is combinational, in the same cycle as the request.
  - s_req = m0_gnt | m1_gnt. s_* fields mux from the granted master; they are 0 when nothing is granted.
  - At most one gnt is high per cycle.
- States: IDLE, GRANT0, GRANT1. The state records the master granted in the previous cycle.
- Grant decision:
  - IDLE: single requester wins. Both requesting: the master != last wins (after reset, m0 wins first).
  - GRANTx, only x requesting: grant x.
  - GRANTx, only the other master requesting: switch immediately.
  - GRANTx, both requesting: keep x if cnt < BURST_MAX, else grant the other master.
  - No requests: go to IDLE; last is retained.
- Counter:
  - On a grant to the same master as the previous cycle: cnt = min(cnt+1, BURST_MAX).
  - On a grant to a different master, or out of IDLE: cnt=1.
  - On no grant: cnt=0.
  - Width is clog2(BURST_MAX+1).
- Read return:
  - A granted read sets a 1-bit valid plus a 1-bit master tag, registered.
  - Next cycle, the tagged master's rvalid=1 and its rdata=s_rdata.
  - The other master's rvalid=0; its rdata holds its last value.
- Writes: no response; gnt is the completion.
- Back-to-back reads (any master mix): one response per cycle, strictly in order.
- Reset mid-operation: a pending read response is discarded; no rvalid after rst is released.
- BURST_MAX=1: under contention, grants strictly alternate.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined:
  - When both masters request, m0 always wins.
  - cnt and BURST_MAX do not affect grants; cnt logic may be removed.
  - Single-requester behaviour and read return are unchanged.
- Undefined: round-robin with burst allowance, as specified above.

Test Plan:
- Reset: hold rst=0 with m0_req=m1_req=1 -> m0_gnt=m1_gnt=0, s_req=0, rvalids=0. Release -> m0 granted in the first cycle.
- Single read: m0 reads addr 0x10, slave returns 0xDEADBEEF -> m0_gnt same cycle, s_addr=0x10, s_we=0. Next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Contention, BURST_MAX=4: both masters issue reads continuously for 16 cycles from reset.
  - Grant sequence is m0×4, m1×4, m0×4, m1×4.
  - Each rvalid appears on the correct master one cycle after its grant.
- Contention, BURST_MAX=1: both masters request for 6 cycles -> grants m0,m1,m0,m1,m0,m1.
- Write passthrough: m1 writes addr 0x20, data 0x12345678, be 0xF while m0 is idle.
  - m1_gnt=1; s_we=1, s_addr=0x20, s_wdata=0x12345678, s_be=0xF.
  - No rvalid follows.
- Reset mid-read plus fixed priority:
  - rst=0 in the cycle after a granted m0 read -> no m0_rvalid after release.
  - With ARB_FIXED_PRIO_EN defined, both masters requesting for 10 cycles -> m0_gnt=1 in all 10 cycles, m1_gnt=0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle for one port of the data-RAM arbiter.
// master: requester view; slave: arbiter view of a requester; mem: arbiter view of the RAM.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                req;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] be;
  logic                gnt;
  logic                rvalid;
  logic [DATA_W-1:0]   rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
  modport mem    (output req, we, addr, wdata, be, input rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave arbiter for the single-port data RAM, round-robin with burst allowance.
// Define ARB_FIXED_PRIO_EN to make master 0 always win under contention.
module mem_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  mem_bus_arbiter_if.mem    s
);

  // state  | meaning
  // IDLE   | nothing granted last cycle
  // GRANT0 | master 0 granted last cycle
  // GRANT1 | master 1 granted last cycle
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last;
  logic                r_rd_vld;
  logic                r_rd_tag;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;
  logic                w_pick0;
  logic                w_pick1;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_rv0;
  logic                w_rv1;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    w_pick0 = m0.req;
    w_pick1 = m1.req & ~m0.req;
  end

  logic w_unused_fixed;
  assign w_unused_fixed = ^{r_state, r_last};
`else
  localparam int              CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_burst_ok;

  assign w_burst_ok = (r_cnt < CNT_MAX);

  // r_last holds the index of the most recently granted master
  always_comb begin
    w_pick0 = 1'b0;
    w_pick1 = 1'b0;
    if (m0.req && m1.req) begin
      case (r_state)
        GRANT0: begin
          w_pick0 = w_burst_ok;
          w_pick1 = ~w_burst_ok;
        end
        GRANT1: begin
          w_pick1 = w_burst_ok;
          w_pick0 = ~w_burst_ok;
        end
        default: begin
          w_pick0 = r_last;
          w_pick1 = ~r_last;
        end
      endcase
    end else begin
      w_pick0 = m0.req;
      w_pick1 = m1.req;
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    if ((w_gnt0 && r_state == GRANT0) || (w_gnt1 && r_state == GRANT1)) begin
      w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    end else if (w_gnt0 || w_gnt1) begin
      w_cnt_nxt = CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= w_cnt_nxt;
  end
`endif

  // grants are gated by reset so nothing reaches the RAM while it is asserted
  assign w_gnt0 = rst & w_pick0;
  assign w_gnt1 = rst & w_pick1;
  assign m0.gnt = w_gnt0;
  assign m1.gnt = w_gnt1;

  always_comb begin
    w_state_nxt = IDLE;
    if (w_gnt0)      w_state_nxt = GRANT0;
    else if (w_gnt1) w_state_nxt = GRANT1;
  end

  always_comb begin
    s.req   = w_gnt0 | w_gnt1;
    s.we    = 1'b0;
    s.addr  = '0;
    s.wdata = '0;
    s.be    = '0;
    if (w_gnt0) begin
      s.we    = m0.we;
      s.addr  = m0.addr;
      s.wdata = m0.wdata;
      s.be    = m0.be;
    end else if (w_gnt1) begin
      s.we    = m1.we;
      s.addr  = m1.addr;
      s.wdata = m1.wdata;
      s.be    = m1.be;
    end
  end

  assign w_rv0     = r_rd_vld & ~r_rd_tag;
  assign w_rv1     = r_rd_vld &  r_rd_tag;
  assign m0.rvalid = w_rv0;
  assign m1.rvalid = w_rv1;
  assign m0.rdata  = w_rv0 ? s.rdata : r_m0_rdata;
  assign m1.rdata  = w_rv1 ? s.rdata : r_m1_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_rd_vld   <= 1'b0;
      r_rd_tag   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      if (w_gnt0)      r_last <= 1'b0;
      else if (w_gnt1) r_last <= 1'b1;
      r_rd_vld <= (w_gnt0 & ~m0.we) | (w_gnt1 & ~m1.we);
      r_rd_tag <= w_gnt1;
      if (w_rv0) r_m0_rdata <= s.rdata;
      if (w_rv1) r_m1_rdata <= s.rdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter; expectations follow ARB_FIXED_PRIO_EN when defined.
// A second instance with BURST_MAX=1 covers strict alternation.
module tb_mem_bus_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam int BURST = 4;

  logic clk;
  logic rst;

  mem_bus_arbiter_if m0_if ();
  mem_bus_arbiter_if m1_if ();
  mem_bus_arbiter_if s_if ();
  mem_bus_arbiter_if bm0_if ();
  mem_bus_arbiter_if bm1_if ();
  mem_bus_arbiter_if bs_if ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(BURST)) u_dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(1)) u_dut_b1 (
    .clk (clk),
    .rst (rst),
    .m0  (bm0_if),
    .m1  (bm1_if),
    .s   (bs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] last_rd0 = '0;
  logic [31:0] last_rd1 = '0;

  typedef struct {
    logic        tag;
    logic [31:0] data;
    int          cyc;
  } rd_t;
  rd_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return (a * 32'h0001_0003) ^ 32'h5A5A_0F0F;
  endfunction

  // RAM model: one-cycle read latency
  logic [31:0] ram_q = '0;
  always @(posedge clk) if (s_if.req && !s_if.we) ram_q <= data_of(s_if.addr);
  assign s_if.rdata   = ram_q;
  assign s_if.gnt     = 1'b0;
  assign s_if.rvalid  = 1'b0;
  assign bs_if.rdata  = '0;
  assign bs_if.gnt    = 1'b0;
  assign bs_if.rvalid = 1'b0;

  // response scoreboard: pop responses from last cycle, then push this cycle's read grants
  always @(negedge clk) begin
    rd_t e;
    cyc++;
    if (!rst) begin
      q.delete();
    end else begin
      if (m0_if.rvalid || m1_if.rvalid) begin
        if (q.size() == 0) begin
          chk("rv_unexp", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rv_who", {62'd0, m1_if.rvalid, m0_if.rvalid}, e.tag ? 2 : 1);
          chk("rv_lat", cyc - e.cyc, 1);
          chk("rv_data", e.tag ? m1_if.rdata : m0_if.rdata, e.data);
          if (e.tag) last_rd1 = e.data;
          else       last_rd0 = e.data;
        end
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("rv_miss", 0, 1);
        void'(q.pop_front());
      end
      if (m0_if.gnt && m1_if.gnt) chk("gnt_excl", 1, 0);
      if (m0_if.gnt && !m0_if.we) q.push_back('{1'b0, data_of(m0_if.addr), cyc});
      if (m1_if.gnt && !m1_if.we) q.push_back('{1'b1, data_of(m1_if.addr), cyc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // both masters stream reads; addresses advance only after acceptance
  task automatic run_contention(input int n, input int first);
    int  exp_m;
    logic g0, g1;
    m0_if.req = 1'b1; m0_if.we = 1'b0;
    m1_if.req = 1'b1; m1_if.we = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp_m = FIXED ? 0 : (first ^ ((i / BURST) % 2));
      g0 = m0_if.gnt;
      g1 = m1_if.gnt;
      chk($sformatf("cont_g0[%0d]", i), g0, exp_m == 0);
      chk($sformatf("cont_g1[%0d]", i), g1, exp_m == 1);
      step();
      if (g0) m0_if.addr = m0_if.addr + 32'd4;
      if (g1) m1_if.addr = m1_if.addr + 32'd4;
    end
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h1000; m0_if.wdata = '0; m0_if.be = 4'hF;
    m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h2000; m1_if.wdata = '0; m1_if.be = 4'hF;
    bm0_if.req = 1'b0; bm0_if.we = 1'b0; bm0_if.addr = '0; bm0_if.wdata = '0; bm0_if.be = '0;
    bm1_if.req = 1'b0; bm1_if.we = 1'b0; bm1_if.addr = '0; bm1_if.wdata = '0; bm1_if.be = '0;

    // reset with both requesting
    repeat (2) @(negedge clk);
    chk("rst_g0", m0_if.gnt, 0);
    chk("rst_g1", m1_if.gnt, 0);
    chk("rst_sreq", s_if.req, 0);
    chk("rst_rv0", m0_if.rvalid, 0);
    chk("rst_rv1", m1_if.rvalid, 0);
    step();
    rst = 1'b1;

    run_contention(16, 0);
    repeat (2) step();

    // single read
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h10;
    @(negedge clk);
    chk("rd_g0", m0_if.gnt, 1);
    chk("rd_g1", m1_if.gnt, 0);
    chk("rd_saddr", s_if.addr, 32'h10);
    chk("rd_swe", s_if.we, 0);
    step();
    m0_if.req = 1'b0;
    @(negedge clk);
    chk("rd_rv0", m0_if.rvalid, 1);
    chk("rd_data0", m0_if.rdata, 32'hDEAD_BEEF);
    chk("rd_rv1", m1_if.rvalid, 0);
    chk("rd_hold1", m1_if.rdata, last_rd1);
    chk("idle_sreq", s_if.req, 0);
    chk("idle_saddr", s_if.addr, 0);
    step();

    // write passthrough from m1
    m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.addr = 32'h20;
    m1_if.wdata = 32'h1234_5678; m1_if.be = 4'hF;
    @(negedge clk);
    chk("wr_g1", m1_if.gnt, 1);
    chk("wr_g0", m0_if.gnt, 0);
    chk("wr_sreq", s_if.req, 1);
    chk("wr_swe", s_if.we, 1);
    chk("wr_saddr", s_if.addr, 32'h20);
    chk("wr_swdata", s_if.wdata, 32'h1234_5678);
    chk("wr_sbe", s_if.be, 4'hF);
    step();
    m1_if.req = 1'b0; m1_if.we = 1'b0;
    @(negedge clk);
    chk("wr_rv0", m0_if.rvalid, 0);
    chk("wr_rv1", m1_if.rvalid, 0);
    step();

    // reset in the cycle after a granted read
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h30;
    @(negedge clk);
    chk("mr_g0", m0_if.gnt, 1);
    step();
    m0_if.req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rv_in_rst", m0_if.rvalid, 0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mr_rv0[%0d]", i), m0_if.rvalid, 0);
      chk($sformatf("mr_rv1[%0d]", i), m1_if.rvalid, 0);
      step();
    end

    // contention after reset, then a retained-last restart
    run_contention(10, 0);
    step();
    run_contention(4, 1);
    repeat (2) step();

    // BURST_MAX=1 instance alternates under contention
    bm0_if.req = 1'b1;
    bm1_if.req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("b1_g0[%0d]", i), bm0_if.gnt, FIXED ? 1'b1 : (i % 2 == 0));
      chk($sformatf("b1_g1[%0d]", i), bm1_if.gnt, FIXED ? 1'b0 : (i % 2 == 1));
      step();
    end
    bm0_if.req = 1'b0;
    bm1_if.req = 1'b0;

    repeat (3) step();
    chk("q_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
